// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the junction controller: 3-bit state encodings, {R,Y,G} light codes
// and the state-to-light decoders used by the output registers.
package traffic_light_fsm_pkg;

    localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED_1   = 3'd2;
    localparam logic [2:0] ST_SIDE_GREEN  = 3'd3;
    localparam logic [2:0] ST_SIDE_YELLOW = 3'd4;
    localparam logic [2:0] ST_ALL_RED_2   = 3'd5;
    localparam logic [2:0] ST_PED_WALK    = 3'd6;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    function automatic logic [2:0] main_light_of(input logic [2:0] state);
        case (state)
            ST_MAIN_GREEN:  return LIGHT_G;
            ST_MAIN_YELLOW: return LIGHT_Y;
            default:        return LIGHT_R;
        endcase
    endfunction

    function automatic logic [2:0] side_light_of(input logic [2:0] state);
        case (state)
            ST_SIDE_GREEN:  return LIGHT_G;
            ST_SIDE_YELLOW: return LIGHT_Y;
            default:        return LIGHT_R;
        endcase
    endfunction

    // A zero duration behaves like one second.
    function automatic int unsigned last_sec(input int unsigned dur);
        return (dur == 0) ? 0 : dur - 1;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_phase_timer.sv
// phase_timer: per-phase second counter. Advances on tick, saturates at all-ones, sync clear
// has priority; done pulses on the tick that completes a phase of i_dur seconds.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_tick,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_dur,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;

    assign w_last = (i_dur == '0) ? '0 : i_dur - CNT_W'(1);

    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = i_tick && (r_cnt == w_last);

endmodule

// File: rtl/traffic_light_fsm.sv
// Junction controller: sequences main/side lights on one-second ticks and serves latched requests.
// Optional pedestrian walk phase is built when the macro PED_WALK_EN is defined.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int MAIN_GREEN_MIN = 10,
    parameter int SIDE_GREEN_T   = 6,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1,
    parameter int PED_WALK_T     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       divider_reset
);

    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(last_sec(MAIN_GREEN_MIN));

    logic [2:0]       r_state;
    logic             r_side_req;
    logic [2:0]       r_main_light;
    logic [2:0]       r_side_light;
    logic             r_div_rst;

    logic [2:0]       w_next_state;
    logic             w_illegal;
    logic             w_clear;
    logic             w_enter_side;
    logic             w_ped_pend;
    logic [CNT_W-1:0] w_dur;
    logic [CNT_W-1:0] w_cnt;
    logic             w_done;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_tick  (tick),
        .i_clear (w_clear),
        .i_dur   (w_dur),
        .o_cnt   (w_cnt),
        .o_done  (w_done)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_dur = CNT_W'(MAIN_GREEN_MIN);
        case (r_state)
            ST_MAIN_YELLOW, ST_SIDE_YELLOW: w_dur = CNT_W'(YELLOW_T);
            ST_ALL_RED_1, ST_ALL_RED_2:     w_dur = CNT_W'(ALL_RED_T);
            ST_SIDE_GREEN:                  w_dur = CNT_W'(SIDE_GREEN_T);
            ST_PED_WALK:                    w_dur = CNT_W'(PED_WALK_T);
            default:                        ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            ST_MAIN_GREEN:
                if (tick && (w_cnt >= MG_LAST) && (r_side_req || w_ped_pend))
                    w_next_state = ST_MAIN_YELLOW;
            ST_MAIN_YELLOW:
                if (w_done) w_next_state = ST_ALL_RED_1;
            ST_ALL_RED_1:
                if (w_done) w_next_state = r_side_req ? ST_SIDE_GREEN
                                         : (w_ped_pend ? ST_PED_WALK : ST_SIDE_GREEN);
            ST_SIDE_GREEN:
                if (w_done) w_next_state = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW:
                if (w_done) w_next_state = ST_ALL_RED_2;
            ST_ALL_RED_2:
                if (w_done) w_next_state = w_ped_pend ? ST_PED_WALK : ST_MAIN_GREEN;
            ST_PED_WALK:
                if (w_done) w_next_state = ST_MAIN_GREEN;
            default: begin
                w_next_state = ST_MAIN_GREEN;
                w_illegal    = 1'b1;
            end
        endcase
    end

    assign w_clear      = w_illegal || (w_next_state != r_state);
    assign w_enter_side = (w_next_state == ST_SIDE_GREEN) && (r_state != ST_SIDE_GREEN);

    // Lights are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_MAIN_GREEN;
            r_side_req   <= 1'b0;
            r_main_light <= LIGHT_G;
            r_side_light <= LIGHT_R;
            r_div_rst    <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_main_light <= main_light_of(w_next_state);
            r_side_light <= side_light_of(w_next_state);
            r_div_rst    <= 1'b0;
            if (w_enter_side)
                r_side_req <= 1'b0;
            else if (side_sensor && (r_state != ST_SIDE_GREEN) && (r_state != ST_SIDE_YELLOW))
                r_side_req <= 1'b1;
        end
    end

`ifdef PED_WALK_EN
    logic r_ped_pend;
    logic r_walk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ped_pend <= 1'b0;
            r_walk     <= 1'b0;
        end else begin
            r_walk <= (w_next_state == ST_PED_WALK);
            if ((w_next_state == ST_PED_WALK) && (r_state != ST_PED_WALK))
                r_ped_pend <= 1'b0;
            else if (ped_req && (r_state != ST_PED_WALK))
                r_ped_pend <= 1'b1;
        end
    end

    assign w_ped_pend = r_ped_pend;
    assign walk       = r_walk;
`else
    logic w_unused_ped;

    assign w_unused_ped = ped_req;
    assign w_ped_pend   = 1'b0;
    assign walk         = 1'b0;
`endif

    assign main_light    = r_main_light;
    assign side_light    = r_side_light;
    assign divider_reset = r_div_rst;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: table of timed vectors, directed corner sequences and random
// stimulus against a phase-queue reference model. Honors PED_WALK_EN like the design.
module tb_traffic_light_fsm;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    localparam int T_MG = 10;
    localparam int T_SG = 6;
    localparam int T_Y  = 3;
    localparam int T_AR = 1;
    localparam int T_PW = 8;

    localparam int K_PLAIN      = 0;
    localparam int K_AFTER_MAIN = 1;
    localparam int K_AFTER_SIDE = 2;

`ifdef PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       side_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       divider_reset;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    traffic_light_fsm #(
        .CNT_W(8), .MAIN_GREEN_MIN(T_MG), .SIDE_GREEN_T(T_SG),
        .YELLOW_T(T_Y), .ALL_RED_T(T_AR), .PED_WALK_T(T_PW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .side_sensor   (side_sensor),
        .ped_req       (ped_req),
        .main_light    (main_light),
        .side_light    (side_light),
        .walk          (walk),
        .divider_reset (divider_reset)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: main green is the idle state (empty queue); a served request
    // queues timed light segments, and decision segments append what follows them.
    typedef struct {
        logic [2:0] ml;
        logic [2:0] sl;
        bit         wk;
        int         len;
        int         kind;
    } seg_t;

    seg_t m_q[$];
    int   m_el;
    int   m_mg;
    bit   m_side;
    bit   m_ped;
    bit   m_div;

    function automatic seg_t mk(logic [2:0] ml, logic [2:0] sl, bit wk, int len, int kind);
        seg_t s;
        s.ml = ml; s.sl = sl; s.wk = wk; s.len = len; s.kind = kind;
        return s;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_el = 0; m_mg = 0; m_side = 1'b0; m_ped = 1'b0; m_div = 1'b1;
    endfunction

    function automatic void model_edge(bit t, bit s, bit p);
        bit busy_side, busy_walk, set_s, set_p, clr_s, clr_p;
        int kind;
        busy_side = (m_q.size() > 0) && (m_q[0].sl != R);
        busy_walk = (m_q.size() > 0) && m_q[0].wk;
        set_s = s && !busy_side;
        set_p = PED_EN && p && !busy_walk;
        clr_s = 1'b0;
        clr_p = 1'b0;
        m_div = 1'b0;
        if (t) begin
            if (m_q.size() == 0) begin
                if ((m_mg >= T_MG - 1) && (m_side || m_ped)) begin
                    m_q.push_back(mk(Y, R, 1'b0, T_Y, K_PLAIN));
                    m_q.push_back(mk(R, R, 1'b0, T_AR, K_AFTER_MAIN));
                    m_el = 0;
                end else begin
                    m_mg++;
                end
            end else begin
                m_el++;
                if (m_el == m_q[0].len) begin
                    kind = m_q[0].kind;
                    void'(m_q.pop_front());
                    m_el = 0;
                    if ((kind == K_AFTER_MAIN && !m_side && m_ped) || (kind == K_AFTER_SIDE && m_ped)) begin
                        m_q.push_back(mk(R, R, 1'b1, T_PW, K_PLAIN));
                        clr_p = 1'b1;
                    end else if (kind == K_AFTER_MAIN) begin
                        m_q.push_back(mk(R, G, 1'b0, T_SG, K_PLAIN));
                        m_q.push_back(mk(R, Y, 1'b0, T_Y, K_PLAIN));
                        m_q.push_back(mk(R, R, 1'b0, T_AR, K_AFTER_SIDE));
                        clr_s = 1'b1;
                    end
                    if (m_q.size() == 0) m_mg = 0;
                end
            end
        end
        m_side = (m_side || set_s) && !clr_s;
        m_ped  = (m_ped || set_p) && !clr_p;
    endfunction

    function automatic logic [2:0] exp_main();
        return (m_q.size() == 0) ? G : m_q[0].ml;
    endfunction

    function automatic logic [2:0] exp_side();
        return (m_q.size() == 0) ? R : m_q[0].sl;
    endfunction

    function automatic bit exp_walk();
        return (m_q.size() == 0) ? 1'b0 : m_q[0].wk;
    endfunction

    // Called at a negedge; applies one clock edge and returns at the following negedge.
    task automatic step(input bit t, input bit s, input bit p);
        tick = t; side_sensor = s; ped_req = p;
        @(posedge clk);
        model_edge(t, s, p);
        #1;
        check("main_light", 8'(main_light), 8'(exp_main()));
        check("side_light", 8'(side_light), 8'(exp_side()));
        check("walk", 8'(walk), 8'(exp_walk()));
        check("divider_reset", 8'(divider_reset), 8'(m_div));
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset between edges and releases it on a later negedge.
    task automatic async_reset();
        #2;
        reset_n = 1'b0; tick = 1'b0; side_sensor = 1'b0; ped_req = 1'b0;
        #1;
        model_reset();
        check("rst_main", 8'(main_light), 8'(G));
        check("rst_side", 8'(side_light), 8'(R));
        check("rst_walk", 8'(walk), 8'h0);
        check("rst_divrst", 8'(divider_reset), 8'h1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("divrst_held", 8'(divider_reset), 8'h1);
    endtask

    always @(negedge clk) begin
        check("inv_main_onehot", 8'($onehot(main_light)), 8'h1);
        check("inv_side_onehot", 8'($onehot(side_light)), 8'h1);
        check("inv_one_road", 8'((main_light == R) || (side_light == R)), 8'h1);
    end

    typedef struct {
        bit         t;
        bit         s;
        bit         p;
        logic [2:0] em;
        logic [2:0] es;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, bit t, bit s, logic [2:0] em, logic [2:0] es);
        vec_t v;
        v.t = t; v.s = s; v.p = 1'b0; v.em = em; v.es = es;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin
        // Side request at tick 2: yellow at 10, all-red 13, side green 14..19, yellow 20..22, red 23, green 24.
        add(1, 1'b1, 1'b0, G, R);
        add(2, 1'b0, 1'b0, G, R);
        add(1, 1'b1, 1'b1, G, R);
        add(7, 1'b1, 1'b0, G, R);
        add(3, 1'b1, 1'b0, Y, R);
        add(1, 1'b1, 1'b0, R, R);
        add(6, 1'b1, 1'b0, R, G);
        add(3, 1'b1, 1'b0, R, Y);
        add(1, 1'b1, 1'b0, R, R);
        add(7, 1'b1, 1'b0, G, R);

        @(negedge clk);
        async_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].t, tbl[i].s, tbl[i].p);
            check("tbl_main", 8'(main_light), 8'(tbl[i].em));
            check("tbl_side", 8'(side_light), 8'(tbl[i].es));
            if (i == 0) check("divrst_release", 8'(divider_reset), 8'h0);
        end

        // No requests: main green held for 30 ticks.
        async_reset();
        for (int k = 1; k <= 30; k++) step(1'b1, 1'b0, 1'b0);
        check("idle_main", 8'(main_light), 8'(G));
        check("idle_side", 8'(side_light), 8'(R));

        // Sensor held through side green then dropped: no re-latch, main green stays.
        async_reset();
        for (int k = 1; k <= 40; k++) step(1'b1, k <= 20, 1'b0);
        check("nolatch_main", 8'(main_light), 8'(G));

        // Sensor held throughout: re-latched after side phase, next main green lasts 10 ticks.
        async_reset();
        for (int k = 1; k <= 35; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 24 || k == 33) check("relatch_green", 8'(main_light), 8'(G));
            if (k == 34) check("relatch_yellow", 8'(main_light), 8'(Y));
        end

        // Pedestrian request at tick 1 with no side traffic.
        async_reset();
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 1'b0, k == 1);
`ifdef PED_WALK_EN
            if (k >= 14 && k <= 21) check("ped_walk_on", 8'(walk), 8'h1);
            if (k == 13 || k == 22) check("ped_walk_off", 8'(walk), 8'h0);
            if (k == 22) check("ped_main_back", 8'(main_light), 8'(G));
`else
            check("ped_ignored_walk", 8'(walk), 8'h0);
            check("ped_ignored_main", 8'(main_light), 8'(G));
`endif
        end

        // Counter saturation: a request after 300 idle ticks is served on the next tick.
        async_reset();
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("sat_still_green", 8'(main_light), 8'(G));
        step(1'b1, 1'b0, 1'b0);
        check("sat_yellow", 8'(main_light), 8'(Y));

        // Reset in the middle of side green, then a latched request lost to reset.
        async_reset();
        for (int k = 1; k <= 16; k++) step(1'b1, k == 2, 1'b0);
        check("mid_side_green", 8'(side_light), 8'(G));
        async_reset();
        step(1'b1, 1'b0, 1'b0);
        check("divrst_low", 8'(divider_reset), 8'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
        async_reset();
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
        check("req_lost_main", 8'(main_light), 8'(G));

        // Random traffic against the reference model.
        async_reset();
        for (int k = 0; k < 4000; k++)
            step($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
